seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   A shadow register captures din whenever din_valid is high. A prescaler
//   divides clk down to one tick per digit slot, and a 2-bit index walks the
//   digits 0..3. The shadow is copied into the display register only when the
//   index wraps 3->0, so a single frame never shows a mix of two values.
//   The an and seg outputs are registered and lag the index/display state
//   by one clock.
//
//   Optional build macro:
//     SEG7_LZ_BLANK_EN - blank leading-zero digits 3..1. When blanked, the
//                        slot keeps its normal timing but an=1111 and
//                        seg=1111111. Digit 0 is never blanked.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam logic [15:0] LP_PRESC_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [1:0]  LP_IDX_LAST   = 2'd3;
    localparam logic [3:0]  LP_AN_OFF     = 4'b1111;
    localparam logic [6:0]  LP_SEG_OFF    = 7'b1111111;

    logic [15:0] r_presc;
    logic [1:0]  r_idx;
    logic [15:0] r_shadow;
    logic [15:0] r_disp;
    logic        r_frame_done;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_tick;
    logic        w_wrap;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg_dec;
    logic        w_blank;
    logic [3:0]  w_an_next;
    logic [6:0]  w_seg_next;

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick = (r_presc == LP_PRESC_LAST);
    assign w_wrap = w_tick && (r_idx == LP_IDX_LAST);

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps; tick marks the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Digit index: advances one slot per tick, 0->1->2->3->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Shadow register: follows din on every valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (din_valid) begin
            r_shadow <= din;
        end
    end

    // Display register: loads the pre-edge shadow on the frame wrap, so a
    // strobe landing on that same edge shows up one frame later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
        end else if (w_wrap) begin
            r_disp <= r_shadow;
        end
    end

    // End-of-frame pulse, high for the cycle after the wrap tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
        end
    end

    // Select the nibble for the current slot.
    always_comb begin
        w_nib = '0;
        case (r_idx)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            default: w_nib = r_disp[15:12];
        endcase
    end

    assign w_seg_dec = hex_to_seg(w_nib);

`ifdef SEG7_LZ_BLANK_EN
    // Leading-zero test: digit k is blank when nibbles k..3 are all zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd0:    w_blank = 1'b0;
            2'd1:    w_blank = (r_disp[15:4] == 12'h000);
            2'd2:    w_blank = (r_disp[15:8] == 8'h00);
            default: w_blank = (r_disp[15:12] == 4'h0);
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    // Next anode/segment pattern: one anode low for the active slot, or all
    // off for a blanked slot.
    always_comb begin
        w_an_next  = LP_AN_OFF;
        w_seg_next = LP_SEG_OFF;
        if (!w_blank) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_seg_dec;
        end
    end

    // Output registers: glitch-free an/seg, one clock behind the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= LP_AN_OFF;
            r_seg <= LP_SEG_OFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-clock frames).
//   Expected anode/segment patterns per digit are hand-written constants.
//   Build with +define+SEG7_LZ_BLANK_EN to select the blanking expectations.
module tb_seg7_scan_driver;

    typedef struct {
        logic [15:0] din;
        logic [15:0] ean;   // {an digit3, digit2, digit1, digit0}
        logic [27:0] eseg;  // {seg digit3, digit2, digit1, digit0}
    } vec_t;

    localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [6:0]  Z      = 7'b1000000;
    localparam logic [6:0]  OFF    = 7'b1111111;
    localparam logic [27:0] SEG_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
    localparam logic [27:0] SEG_BEEF = {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
    localparam logic [27:0] SEG_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl [6];

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Wait for frame_done, counting negedges; compare count to exp_n.
    task automatic wait_fd(input string nm, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) break;
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    // Check one 16-clock frame starting at a negedge where frame_done=1.
    // Optional input change after sample chg_cyc; drop strobe after the next.
    task automatic check_frame(input string nm, input logic [15:0] ean,
                               input logic [27:0] eseg, input int chg_cyc,
                               input logic [15:0] chg_din, input logic chg_valid,
                               input bit drop);
        int unsigned slot;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            slot = 32'(c - 1) / 4;
            chk($sformatf("%s c%0d an", nm, c), 32'(an), 32'(ean[slot*4 +: 4]));
            chk($sformatf("%s c%0d seg", nm, c), 32'(seg), 32'(eseg[slot*7 +: 7]));
            chk($sformatf("%s c%0d frame_done", nm, c), 32'(frame_done), 32'(c == 16));
            if (c == chg_cyc) begin
                din       = chg_din;
                din_valid = chg_valid;
            end
            if (drop && c == chg_cyc + 1) begin
                din_valid = 1'b0;
                din       = 16'h1111;
            end
        end
    endtask

    initial begin
        tbl[0] = '{din: 16'h0000,
`ifdef SEG7_LZ_BLANK_EN
                   ean: {4'b1111, 4'b1111, 4'b1111, 4'b1110}, eseg: {OFF, OFF, OFF, Z}};
`else
                   ean: AN_ALL, eseg: {Z, Z, Z, Z}};
`endif
        tbl[1] = '{din: 16'hA5F1, ean: AN_ALL,
                   eseg: {7'b0001000, 7'b0010010, 7'b0001110, 7'b1111001}};
        tbl[2] = '{din: 16'h1234, ean: AN_ALL, eseg: SEG_1234};
        tbl[3] = '{din: 16'h0030,
`ifdef SEG7_LZ_BLANK_EN
                   ean: {4'b1111, 4'b1111, 4'b1101, 4'b1110}, eseg: {OFF, OFF, 7'b0110000, Z}};
`else
                   ean: AN_ALL, eseg: {Z, Z, 7'b0110000, Z}};
`endif
        tbl[4] = '{din: 16'h6789, ean: AN_ALL,
                   eseg: {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000}};
        tbl[5] = '{din: 16'hBCDE, ean: AN_ALL,
                   eseg: {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}};

        // Reset state
        rst = 1'b1; din = 16'h0000; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset frame_done", 32'(frame_done), 32'h0);

        // First edge after release shows digit 0 as '0'
        rst = 1'b0;
        @(posedge clk); #1;
        chk("release an", 32'(an), 32'hE);
        chk("release seg", 32'(seg), 32'(Z));
        wait_fd("first frame_done latency", 16);

        // Table: each value first shows the previous frame, then itself
        din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int p;
            p = (i == 0) ? 0 : i - 1;
            din = tbl[i].din;
            check_frame($sformatf("vec%0d prev", i), tbl[p].ean, tbl[p].eseg, 0, 16'h0, 1'b1, 1'b0);
            check_frame($sformatf("vec%0d %h", i, tbl[i].din), tbl[i].ean, tbl[i].eseg, 0, 16'h0, 1'b1, 1'b0);
        end

        // Coherence: din changes during digit 2 slot
        din = 16'h1234;
        check_frame("coh prev", tbl[5].ean, tbl[5].eseg, 0, 16'h0, 1'b1, 1'b0);
        check_frame("coh 1234", AN_ALL, SEG_1234, 9, 16'h5678, 1'b1, 1'b0);
        check_frame("coh 5678", AN_ALL, SEG_5678, 0, 16'h0, 1'b1, 1'b0);

        // Simultaneity: strobe BEEF exactly on the wrap edge
        din_valid = 1'b0; din = 16'h0000;
        check_frame("sim strobe", AN_ALL, SEG_5678, 15, 16'hBEEF, 1'b1, 1'b1);
        check_frame("sim old", AN_ALL, SEG_5678, 0, 16'h0, 1'b0, 1'b0);
        check_frame("sim BEEF", AN_ALL, SEG_BEEF, 0, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst an", 32'(an), 32'hF);
        chk("async rst seg", 32'(seg), 32'h7F);
        chk("async rst frame_done", 32'(frame_done), 32'h0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("in rst c%0d frame_done", i), 32'(frame_done), 32'h0);
            chk($sformatf("in rst c%0d an", i), 32'(an), 32'hF);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("re-release an", 32'(an), 32'hE);
        chk("re-release seg", 32'(seg), 32'(Z));
        wait_fd("frame_done after mid-frame reset", 16);
        check_frame("post reset", tbl[0].ean, tbl[0].eseg, 0, 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
